// File: rtl/taylor_pkg.sv
// Shared types for the Taylor-series angle sweep: data width, fixed-point one,
// controller states and the (angle, cos) result record.
package taylor_pkg;

  localparam int W = 24;
  localparam logic [W-1:0] FXP_ONE = 24'd8388608;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_STORE,
    S_NEXT,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [W-1:0] angle;
    logic [W-1:0] cos;
  } taylor_result_t;

endpackage

// File: rtl/sweep_result_fifo.sv
// First-word-fall-through result FIFO; a push is visible one cycle later.
// A push while full succeeds only when a pop happens in the same cycle.
module sweep_result_fifo
  import taylor_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic           clock_i,
  input  logic           reset_i,
  input  logic           push_i,
  input  taylor_result_t push_dat_i,
  input  logic           pop_i,
  output taylor_result_t head_o,
  output logic           valid_o,
  output logic           full_o,
  output logic [CW-1:0]  count_o
);

  taylor_result_t mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           push_ok;
  logic           pop_ok;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign pop_ok  = pop_i & valid_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clock_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/taylor_sweep_ctrl.sv
// Sweeps angles through one TaylorSeries core (start/ready) and queues each (angle, cos).
// Stalls in STORE while the FIFO is full; TAYLOR_SWEEP_TIMEOUT_EN adds a per-request watchdog.
module taylor_sweep_ctrl
  import taylor_pkg::*;
#(
  parameter int           DEPTH       = 16,
  parameter logic [W-1:0] ANGLE_START = 24'd4194304,
  parameter logic [W-1:0] ANGLE_STOP  = 24'd12582912,
  parameter logic [W-1:0] ANGLE_STEP  = 24'd838861,
`ifdef TAYLOR_SWEEP_TIMEOUT_EN
  parameter int           TIMEOUT_CYC = 256,
`endif
  localparam int          CW          = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          run_in,
  output logic          busy_out,
  output logic          done_out,
  output logic          core_start_out,
  output logic [W-1:0]  core_angle_out,
  input  logic          core_ready_in,
  input  logic [W-1:0]  core_cos_in,
  input  logic          rd_en_in,
  output logic          rd_valid_out,
  output logic [W-1:0]  rd_angle_out,
  output logic [W-1:0]  rd_cos_out,
  output logic [CW-1:0] count_out,
  output logic          err_out
);

  state_e         state_q, state_d;
  logic [W-1:0]   angle_q, angle_d;
  logic [W-1:0]   cos_q, cos_d;
  logic           err_q, err_d;
  logic           rdy_prev_q;
  logic [W:0]     sum;
  logic           rise;
  logic           timeout;
  logic           push;
  logic           fifo_full;
  taylor_result_t wr_dat;
  taylor_result_t head;

  // Extra carry bit so a step past 2^W is seen as the end of the sweep.
  assign sum    = {1'b0, angle_q} + {1'b0, ANGLE_STEP};
  assign rise   = core_ready_in & ~rdy_prev_q;
  assign wr_dat = '{angle: angle_q, cos: cos_q};

`ifdef TAYLOR_SWEEP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wd_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_q <= '0;
    end else if (state_q == S_ISSUE) begin
      wd_q <= '0;
    end else if (state_q == S_WAIT) begin
      wd_q <= wd_q + 1'b1;
    end
  end

  assign timeout = (wd_q == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      angle_q    <= ANGLE_START;
      cos_q      <= '0;
      err_q      <= 1'b0;
      rdy_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      angle_q    <= angle_d;
      cos_q      <= cos_d;
      err_q      <= err_d;
      rdy_prev_q <= core_ready_in;
    end
  end

  always_comb begin
    state_d        = state_q;
    angle_d        = angle_q;
    cos_d          = cos_q;
    err_d          = err_q;
    push           = 1'b0;
    busy_out       = 1'b0;
    done_out       = 1'b0;
    core_start_out = 1'b0;
    core_angle_out = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        done_out = (state_q == S_DONE);
        if (run_in) begin
          state_d = S_ISSUE;
          angle_d = ANGLE_START;
          err_d   = 1'b0;
        end
      end
      S_ISSUE: begin
        busy_out       = 1'b1;
        core_start_out = 1'b1;
        core_angle_out = angle_q;
        state_d        = S_WAIT;
      end
      S_WAIT: begin
        busy_out       = 1'b1;
        core_angle_out = angle_q;
        if (rise) begin
          cos_d   = core_cos_in;
          state_d = S_STORE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_STORE: begin
        busy_out       = 1'b1;
        core_angle_out = angle_q;
        if (!fifo_full || rd_en_in) begin
          push    = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        busy_out = 1'b1;
        if (sum[W] || (sum[W-1:0] > ANGLE_STOP)) begin
          state_d = S_DONE;
        end else begin
          angle_d = sum[W-1:0];
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  sweep_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock_i    (clock),
    .reset_i    (reset),
    .push_i     (push),
    .push_dat_i (wr_dat),
    .pop_i      (rd_en_in),
    .head_o     (head),
    .valid_o    (rd_valid_out),
    .full_o     (fifo_full),
    .count_o    (count_out)
  );

  assign rd_angle_out = head.angle;
  assign rd_cos_out   = head.cos;
  assign err_out      = err_q;

endmodule

// File: tb/tb_taylor_sweep_ctrl.sv
// Bench for taylor_sweep_ctrl: three instances (default, DEPTH=4, wrapping step)
// each driven by a behavioural core that answers 20 cycles after start.
module tb_taylor_sweep_ctrl;

  localparam int NI = 3;
  localparam int          DEP [NI] = '{16, 4, 16};
  localparam logic [23:0] ST0 [NI] = '{24'd4194304, 24'd4194304, 24'd12582912};
  localparam logic [23:0] STP [NI] = '{24'd12582912, 24'd12582912, 24'd16777215};
  localparam logic [23:0] STE [NI] = '{24'd838861, 24'd838861, 24'd8388608};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [NI];
  logic        run [NI];
  logic        rd_en [NI];
  logic        busy [NI];
  logic        done [NI];
  logic        cstart [NI];
  logic        rvld [NI];
  logic        err [NI];
  logic [23:0] cang [NI];
  logic [23:0] rang [NI];
  logic [23:0] rcos [NI];
  logic [4:0]  cnt [NI];
  logic        mute [NI];
  logic        force_hi [NI];

  logic        crdy [NI]   = '{1'b0, 1'b0, 1'b0};
  logic [23:0] ccos [NI]   = '{24'd0, 24'd0, 24'd0};
  int          cd [NI]     = '{0, 0, 0};
  logic        rp [NI]     = '{1'b0, 1'b0, 1'b0};
  logic [23:0] pa [NI]     = '{24'd0, 24'd0, 24'd0};
  int          nstart [NI] = '{0, 0, 0};

  int errors = 0;
  int checks = 0;
  logic [23:0] expq [$];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [$clog2(DEP[g]):0] c;
    taylor_sweep_ctrl #(
      .DEPTH       (DEP[g]),
      .ANGLE_START (ST0[g]),
      .ANGLE_STOP  (STP[g]),
      .ANGLE_STEP  (STE[g])
    ) u_dut (
      .clock          (clk),
      .reset          (rst[g]),
      .run_in         (run[g]),
      .busy_out       (busy[g]),
      .done_out       (done[g]),
      .core_start_out (cstart[g]),
      .core_angle_out (cang[g]),
      .core_ready_in  (crdy[g]),
      .core_cos_in    (ccos[g]),
      .rd_en_in       (rd_en[g]),
      .rd_valid_out   (rvld[g]),
      .rd_angle_out   (rang[g]),
      .rd_cos_out     (rcos[g]),
      .count_out      (c),
      .err_out        (err[g])
    );
    assign cnt[g] = 5'(c);
  end

  function automatic logic [23:0] cos_fx(input logic [23:0] a);
    real r;
    r = $cos(real'(a) / 8388608.0) * 8388608.0;
    return 24'($rtoi(r + 0.5));
  endfunction

  // Core model: ready rises 20 cycles after a start pulse; force_hi keeps it
  // high through the start and then gives a one-cycle low before the real rise.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (cstart[i]) begin
        nstart[i] <= nstart[i] + 1;
        pa[i]     <= cang[i];
        crdy[i]   <= force_hi[i];
        cd[i]     <= mute[i] ? 0 : 20;
        rp[i]     <= 1'b0;
      end else if (cd[i] > 1) begin
        cd[i] <= cd[i] - 1;
      end else if (cd[i] == 1) begin
        cd[i] <= 0;
        if (force_hi[i]) begin
          crdy[i] <= 1'b0;
          rp[i]   <= 1'b1;
        end else begin
          crdy[i] <= 1'b1;
          ccos[i] <= cos_fx(pa[i]);
        end
      end else if (rp[i]) begin
        rp[i]   <= 1'b0;
        crdy[i] <= 1'b1;
        ccos[i] <= cos_fx(pa[i]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_run(input int i);
    run[i] = 1'b1;
    @(negedge clk);
    run[i] = 1'b0;
  endtask

  // Expected angle sequence straight from the sweep rule: stop once the next
  // angle would pass ANGLE_STOP or overflow the 24-bit range.
  task automatic build_exp(input int i);
    longint a, s;
    expq.delete();
    a = longint'(ST0[i]);
    while (1) begin
      expq.push_back(a[23:0]);
      s = a + longint'(STE[i]);
      if (s >= 64'd16777216 || s > longint'(STP[i])) break;
      a = s;
    end
  endtask

  // Pops entries at random moments until the sweep is done and the FIFO empty,
  // checking each popped head against expq in order.
  task automatic read_all(input int i, input int budget, input string nm);
    int k = 0;
    int t = 0;
    int d;
    while (t < budget && !(done[i] && !rvld[i])) begin
      if (rvld[i] && $urandom_range(0, 3) != 0) begin
        checks++;
        if (k >= expq.size() || rang[i] !== expq[k]) begin
          errors++;
          $display("FAIL %s angle[%0d]: got %0d want %0d", nm, k, rang[i],
                   (k < expq.size()) ? expq[k] : 24'd0);
        end
        d = int'(rcos[i]) - int'(cos_fx(rang[i]));
        checks++;
        if (d > 1 || d < -1) begin
          errors++;
          $display("FAIL %s cos[%0d]: got %0d want %0d +-1", nm, k, rcos[i], cos_fx(rang[i]));
        end
        rd_en[i] = 1'b1;
        k++;
      end else begin
        rd_en[i] = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    rd_en[i] = 1'b0;
    checks++;
    if (k != expq.size() || t >= budget) begin
      errors++;
      $display("FAIL %s entries: got %0d want %0d (cycles %0d of %0d)", nm, k, expq.size(), t, budget);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; run[i] = 1'b0; rd_en[i] = 1'b0; mute[i] = 1'b0; force_hi[i] = 1'b0;
    end
    cyc(3);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({busy[i], done[i], cstart[i], rvld[i], err[i]} !== 5'b0 || cang[i] !== 24'd0 || cnt[i] !== 5'd0) begin
        errors++;
        $display("FAIL reset[%0d]: flags=%b angle=%0d count=%0d want all 0", i,
                 {busy[i], done[i], cstart[i], rvld[i], err[i]}, cang[i], cnt[i]);
      end
      rst[i] = 1'b0;
    end
    cyc(2);
  endtask

  task automatic test_default_sweep();
    int n0 = nstart[0];
    int t = 0;
    int again = $urandom_range(30, 200);
    build_exp(0);
    cyc($urandom_range(0, 5));
    pulse_run(0);
    checks++;
    if (!cstart[0] || !busy[0] || cang[0] !== ST0[0]) begin
      errors++;
      $display("FAIL sweep_issue: start=%b busy=%b angle=%0d want 1 1 %0d", cstart[0], busy[0], cang[0], ST0[0]);
    end
    while (!done[0] && t < 2000) begin
      run[0] = (t == again);
      @(negedge clk);
      t++;
    end
    run[0] = 1'b0;
    checks++;
    if (!done[0] || busy[0]) begin
      errors++;
      $display("FAIL sweep_done: done=%b busy=%b want 1 0", done[0], busy[0]);
    end
    checks++;
    if (int'(cnt[0]) != expq.size() || nstart[0] - n0 != expq.size()) begin
      errors++;
      $display("FAIL sweep_count: count=%0d requests=%0d want %0d", cnt[0], nstart[0] - n0, expq.size());
    end
    read_all(0, 200, "sweep_read");
    checks++;
    if (cnt[0] !== 5'd0 || !done[0]) begin
      errors++;
      $display("FAIL sweep_drained: count=%0d done=%b want 0 1", cnt[0], done[0]);
    end
  endtask

  task automatic test_back_to_back();
    int n0 = nstart[0];
    build_exp(0);
    pulse_run(0);
    read_all(0, 3000, "rerun_read");
    checks++;
    if (nstart[0] - n0 != expq.size() || !done[0]) begin
      errors++;
      $display("FAIL rerun_requests: got %0d done=%b want %0d 1", nstart[0] - n0, done[0], expq.size());
    end
  endtask

  task automatic test_full_stall();
    int n0 = nstart[1];
    build_exp(1);
    pulse_run(1);
    cyc(400);
    checks++;
    if (cnt[1] !== 5'd4 || !busy[1] || done[1] || nstart[1] - n0 != 5) begin
      errors++;
      $display("FAIL stall: count=%0d busy=%b done=%b requests=%0d want 4 1 0 5",
               cnt[1], busy[1], done[1], nstart[1] - n0);
    end
    checks++;
    if (rang[1] !== expq[0]) begin
      errors++;
      $display("FAIL stall_head: got %0d want %0d", rang[1], expq[0]);
    end
    rd_en[1] = 1'b1;
    @(negedge clk);
    rd_en[1] = 1'b0;
    checks++;
    if (cnt[1] !== 5'd4) begin
      errors++;
      $display("FAIL stall_push_pop: count=%0d want 4", cnt[1]);
    end
    cyc(200);
    checks++;
    if (cnt[1] !== 5'd4 || nstart[1] - n0 != 6 || rang[1] !== expq[1]) begin
      errors++;
      $display("FAIL stall_one_more: count=%0d requests=%0d head=%0d want 4 6 %0d",
               cnt[1], nstart[1] - n0, rang[1], expq[1]);
    end
    void'(expq.pop_front());
    read_all(1, 3000, "stall_drain");
  endtask

  task automatic test_reset_in_wait();
    int n0 = nstart[0];
    int t = 0;
    pulse_run(0);
    while (nstart[0] - n0 < 3 && t < 500) begin
      @(negedge clk);
      t++;
    end
    cyc(5);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    checks++;
    if ({busy[0], done[0], cstart[0], rvld[0], err[0]} !== 5'b0 || cang[0] !== 24'd0 || cnt[0] !== 5'd0) begin
      errors++;
      $display("FAIL wait_reset: flags=%b angle=%0d count=%0d want all 0",
               {busy[0], done[0], cstart[0], rvld[0], err[0]}, cang[0], cnt[0]);
    end
    cyc(40);
    checks++;
    if (cnt[0] !== 5'd0 || busy[0] || nstart[0] - n0 != 3) begin
      errors++;
      $display("FAIL late_ready: count=%0d busy=%b requests=%0d want 0 0 3", cnt[0], busy[0], nstart[0] - n0);
    end
    pulse_run(0);
    checks++;
    if (!cstart[0] || cang[0] !== 24'd4194304) begin
      errors++;
      $display("FAIL restart_angle: start=%b angle=%0d want 1 4194304", cstart[0], cang[0]);
    end
    build_exp(0);
    read_all(0, 3000, "restart_read");
  endtask

  task automatic test_ready_held_high();
    build_exp(0);
    force_hi[0] = 1'b1;
    pulse_run(0);
    cyc(19);
    checks++;
    if (cnt[0] !== 5'd0 || !busy[0]) begin
      errors++;
      $display("FAIL held_high_no_capture: count=%0d busy=%b want 0 1", cnt[0], busy[0]);
    end
    cyc(6);
    checks++;
    if (cnt[0] !== 5'd1 || rang[0] !== expq[0]) begin
      errors++;
      $display("FAIL held_high_capture: count=%0d head=%0d want 1 %0d", cnt[0], rang[0], expq[0]);
    end
    read_all(0, 3000, "held_high_read");
    force_hi[0] = 1'b0;
  endtask

  task automatic test_wrap();
    int n0 = nstart[2];
    int t = 0;
    build_exp(2);
    pulse_run(2);
    while (!done[2] && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!done[2] || cnt[2] !== 5'd1 || nstart[2] - n0 != 1 || rang[2] !== 24'd12582912) begin
      errors++;
      $display("FAIL wrap: done=%b count=%0d requests=%0d head=%0d want 1 1 1 12582912",
               done[2], cnt[2], nstart[2] - n0, rang[2]);
    end
    read_all(2, 100, "wrap_read");
  endtask

  task automatic test_timeout();
    mute[0] = 1'b1;
    pulse_run(0);
    cyc(200);
    checks++;
    if (err[0] || !busy[0]) begin
      errors++;
      $display("FAIL timeout_early: err=%b busy=%b want 0 1", err[0], busy[0]);
    end
`ifdef TAYLOR_SWEEP_TIMEOUT_EN
    begin
      int t = 0;
      while (!done[0] && t < 200) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (!done[0] || !err[0] || busy[0] || cnt[0] !== 5'd0 || t < 50) begin
        errors++;
        $display("FAIL timeout_fire: done=%b err=%b busy=%b count=%0d after %0d more cycles",
                 done[0], err[0], busy[0], cnt[0], t);
      end
      pulse_run(0);
      checks++;
      if (err[0]) begin
        errors++;
        $display("FAIL timeout_clear: err=%b want 0", err[0]);
      end
    end
`else
    cyc(200);
    checks++;
    if (err[0] || !busy[0] || done[0]) begin
      errors++;
      $display("FAIL no_watchdog: err=%b busy=%b done=%b want 0 1 0", err[0], busy[0], done[0]);
    end
`endif
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    mute[0] = 1'b0;
    cyc(2);
  endtask

  initial begin
    test_reset();
    test_default_sweep();
    test_back_to_back();
    test_full_stall();
    test_reset_in_wait();
    test_ready_held_high();
    test_wrap();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
